// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Shares a single-port, synchronous-read framebuffer RAM
//               between VGA scan-out and a host valid/ready port. Scan-out
//               owns one fixed fetch slot per 4-pixel cell; the host gets
//               every other cycle. Drives the registered 3-bit pixel colour.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int H_TOTAL  = 800,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525,
   parameter int FB_W     = 160,
   parameter int FB_CELLS = 19200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        host_valid,
   output logic        host_ready,
   input  logic        host_we,
   input  logic [14:0] host_addr,
   input  logic [2:0]  host_wdata,
   output logic        host_rvalid,
   output logic [2:0]  host_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [14:0] mem_addr,
   output logic [2:0]  mem_wdata,
   input  logic [2:0]  mem_rdata,
   output logic [2:0]  pix_rgb
);

   // Timing constants sized to the counter widths.
   localparam logic [9:0]  c_h_active     = 10'(H_ACTIVE);
   localparam logic [9:0]  c_v_active     = 10'(V_ACTIVE);
   // Last in-line fetch: slot at H_ACTIVE-6 looks ahead to the final cell.
   localparam logic [9:0]  c_h_last_fetch = 10'(H_ACTIVE - 6);
   // End-of-line slot fetching cell 0 of the next line.
   localparam logic [9:0]  c_h_wrap_slot  = 10'(H_TOTAL - 2);
   localparam logic [9:0]  c_v_last       = 10'(V_TOTAL - 1);
   localparam logic [14:0] c_fb_w         = 15'(FB_W);
   localparam logic [14:0] c_fb_cells     = 15'(FB_CELLS);

   // Combinational nets.
   logic [9:0]  w_next_line;
   logic [9:0]  w_nx_sum;
   logic        w_line_slot;
   logic        w_wrap_slot;
   logic        w_slot_pos;
   logic        w_slot;
   logic [7:0]  w_nx;
   logic [7:0]  w_ny;
   logic [14:0] w_disp_addr;
   logic        w_host_acc;
   logic        w_host_in_range;
   logic        w_visible;

   // Registered state and next-state values.
   logic        slot_q,   slot_d;
   logic [2:0]  cell_q,   cell_d;
   logic [2:0]  pix_q,    pix_d;
   logic        rvalid_q, rvalid_d;
   logic        rd_inr_q, rd_inr_d;

   // Display slot decode and lookahead cell address.
   always_comb begin
      w_next_line = (vcount == c_v_last) ? 10'd0 : vcount + 10'd1;
      w_nx_sum    = hcount + 10'd2;
      w_line_slot = (hcount[1:0] == 2'b10) && (hcount <= c_h_last_fetch) &&
                    (vcount < c_v_active);
      w_wrap_slot = (hcount == c_h_wrap_slot) && (w_next_line < c_v_active);
      w_slot_pos  = w_line_slot || w_wrap_slot;
      w_slot      = w_slot_pos && !rst;
      w_nx        = w_line_slot ? w_nx_sum[9:2] : 8'd0;
      w_ny        = w_line_slot ? vcount[9:2] : w_next_line[9:2];
      // Constant multiplier: synthesis reduces it to shift-add.
      w_disp_addr = ({7'd0, w_ny} * c_fb_w) + {7'd0, w_nx};
   end

   // Host handshake: ready in every cycle that is not a display slot.
   always_comb begin
      host_ready      = !rst && !w_slot_pos;
      w_host_acc      = host_valid && host_ready;
      w_host_in_range = host_addr < c_fb_cells;
   end

   // RAM port mux: display slot first, then in-range host access, else idle.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 15'd0;
      mem_wdata = 3'd0;
      if (w_slot) begin
         mem_en   = 1'b1;
         mem_addr = w_disp_addr;
      end else if (w_host_acc && w_host_in_range) begin
         mem_en    = 1'b1;
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   // Next-state for the fetch pipeline, pixel register and read return.
   always_comb begin
      w_visible = (hcount < c_h_active) && (vcount < c_v_active);
      slot_d    = w_slot;
      cell_d    = slot_q ? mem_rdata : cell_q;
      pix_d     = w_visible ? cell_q : 3'd0;
      rvalid_d  = w_host_acc && !host_we;
      rd_inr_d  = w_host_acc && !host_we && w_host_in_range;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q   <= 1'b0;
         cell_q   <= 3'd0;
         pix_q    <= 3'd0;
         rvalid_q <= 1'b0;
         rd_inr_q <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         cell_q   <= cell_d;
         pix_q    <= pix_d;
         rvalid_q <= rvalid_d;
         rd_inr_q <= rd_inr_d;
      end
   end

   // Read return; suppressed while reset is asserted so an in-flight read
   // never surfaces. Out-of-range reads return 0.
   always_comb begin
      host_rvalid = rvalid_q && !rst;
      host_rdata  = (rvalid_q && rd_inr_q && !rst) ? mem_rdata : 3'd0;
      pix_rgb     = pix_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_arbiter
// Description : Self-checking bench for vga_fb_arbiter with a behavioural
//               RAM, a framebuffer model and pixel/read-return scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  hcount, vcount;
   logic        host_valid, host_ready, host_we;
   logic [14:0] host_addr;
   logic [2:0]  host_wdata;
   logic        host_rvalid;
   logic [2:0]  host_rdata;
   logic        mem_en, mem_we;
   logic [14:0] mem_addr;
   logic [2:0]  mem_wdata, mem_rdata;
   logic [2:0]  pix_rgb;

   vga_fb_arbiter dut (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
      .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pix_rgb(pix_rgb)
   );

   always #20 clk = ~clk;

   // Behavioural single-port synchronous-read RAM.
   logic [2:0] ram [0:32767];
   logic [2:0] ram_rd;
   logic       ram_clr;
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 32768; i++) ram[i] <= 3'd0;
         ram_rd <= 3'd0;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        ram_rd <= ram[mem_addr];
      end
   end
   assign mem_rdata = ram_rd;

   // Framebuffer model and scoreboards.
   logic [2:0]  exp_fb [0:19199];
   logic [31:0] pq[$];
   logic [31:0] rq[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic        last_acc;
   logic        auto_rd;
   int          rd_idx;
   int          rd_tbl [0:5] = '{1, 19200, 161, 0, 320, 2};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at v=%0d h=%0d: got %0d expected %0d", tag, vcount, hcount, obs, exp);
      end
   endtask

   function automatic bit exp_slot(input int h, input int v, output int addr);
      int nl;
      addr = 0;
      if ((h % 4) == 2 && h >= 2 && h <= 634 && v < 480) begin
         addr = (v / 4) * 160 + (h + 2) / 4;
         return 1'b1;
      end
      if (h == 798) begin
         nl = (v == 524) ? 0 : v + 1;
         if (nl < 480) begin
            addr = (nl / 4) * 160;
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [31:0] exp_pix(input int h, input int v);
      if (h < 640 && v < 480) return 32'(exp_fb[(v / 4) * 160 + h / 4]);
      return 32'd0;
   endfunction

   // One clock: check at the falling edge, advance stimulus after the rise.
   task automatic do_cycle();
      bit          s;
      int          a;
      logic [31:0] e;
      @(negedge clk);
      last_acc = 1'b0;
      if (pq.size() > 0) begin
         e = pq.pop_front();
         check_eq("pix", pix_rgb, e);
      end
      if (rst) begin
         rq.delete();
         check_eq("rst_ready", host_ready, 0);
         check_eq("rst_mem_en", mem_en, 0);
         check_eq("rst_mem_we", mem_we, 0);
         check_eq("rst_rvalid", host_rvalid, 0);
         pq.push_back(32'd0);
      end else begin
         if (rq.size() > 0) begin
            e = rq.pop_front();
            check_eq("rvalid", host_rvalid, 1);
            check_eq("rdata", host_rdata, e);
         end else begin
            check_eq("rvalid_idle", host_rvalid, 0);
         end
         s = exp_slot(int'(hcount), int'(vcount), a);
         check_eq("ready", host_ready, !s);
         last_acc = host_valid && host_ready;
         if (s) begin
            check_eq("slot_en", mem_en, 1);
            check_eq("slot_we", mem_we, 0);
            check_eq("slot_addr", mem_addr, a);
         end else if (host_valid) begin
            if (host_addr < 15'd19200) begin
               check_eq("host_en", mem_en, 1);
               check_eq("host_we", mem_we, host_we);
               check_eq("host_addr", mem_addr, host_addr);
               if (host_we) begin
                  check_eq("host_wdata", mem_wdata, host_wdata);
                  exp_fb[host_addr] = host_wdata;
               end
            end else begin
               check_eq("oor_en", mem_en, 0);
            end
            if (!host_we)
               rq.push_back((host_addr < 15'd19200) ? 32'(exp_fb[host_addr]) : 32'd0);
         end else begin
            check_eq("idle_en", mem_en, 0);
            check_eq("idle_we", mem_we, 0);
         end
         pq.push_back(exp_pix(int'(hcount), int'(vcount)));
      end
      @(posedge clk);
      #1;
      if (hcount == 10'd799) begin
         hcount = 10'd0;
         vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
      end else begin
         hcount = hcount + 10'd1;
      end
      if (auto_rd && last_acc) begin
         rd_idx++;
         host_addr = 15'(rd_tbl[rd_idx % 6]);
      end
   endtask

   task automatic host_req(input bit we, input int addr, input int data);
      host_valid = 1'b1;
      host_we    = we;
      host_addr  = 15'(addr);
      host_wdata = 3'(data);
      for (int k = 0; k < 8; k++) begin
         do_cycle();
         if (last_acc) break;
      end
      check_eq("host_accept", last_acc, 1);
      host_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 19200; i++) exp_fb[i] = 3'd0;
      ram_clr    = 1'b1;
      rst        = 1'b1;
      hcount     = 10'd100;
      vcount     = 10'd500;
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = 15'd5;
      host_wdata = 3'd0;
      auto_rd    = 1'b0;
      rd_idx     = 0;
      pq.push_back(32'd0);
      @(posedge clk);
      #1;
      // Reset held three cycles with a pending host request.
      repeat (3) do_cycle();
      ram_clr    = 1'b0;
      rst        = 1'b0;
      host_valid = 1'b0;
      do_cycle();

      // Vertical blanking writes, including a dropped out-of-range write.
      host_req(1, 0, 3'b100);
      host_req(1, 1, 3'b010);
      host_req(1, 2, 3'b111);
      host_req(1, 160, 3'b001);
      host_req(1, 161, 3'b011);
      host_req(1, 162, 3'b101);
      host_req(1, 320, 3'b110);
      host_req(1, 19200, 3'b111);
      do_cycle();

      // Reads: in range, out of range, then a read killed by reset.
      host_req(0, 1, 0);
      host_req(0, 19200, 0);
      do_cycle();
      host_req(0, 0, 0);
      rst = 1'b1;
      do_cycle();
      rst = 1'b0;
      do_cycle();
      do_cycle();

      // Scan-out from the frame wrap through line 10, host reading constantly.
      hcount     = 10'd796;
      vcount     = 10'd524;
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = 15'(rd_tbl[0]);
      auto_rd    = 1'b1;
      for (int k = 0; k < 10000; k++) begin
         if (vcount == 10'd11 && hcount == 10'd0) break;
         do_cycle();
      end
      auto_rd    = 1'b0;
      host_valid = 1'b0;
      do_cycle();

      // Last visible line: no wrap fetch at hcount 798.
      hcount = 10'd790;
      vcount = 10'd479;
      repeat (14) do_cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Shares a single-port, synchronous-read framebuffer RAM between the VGA scan-out path and a host write/read port. Scan-out gets guaranteed, fixed-schedule fetch slots; the host gets every remaining cycle through a valid/ready handshake. The block sits between the `vga` timing generator (which supplies `hcount`/`vcount`) and the RAM, and drives the registered 3-bit pixel colour toward the DAC/pins. The framebuffer is 160×120 cells of 3-bit RGB, each cell scaled to 4×4 pixels of the 640×480 image; the pixel clock is 25 MHz (40 ns).

## Interface

Parameters:

- `H_ACTIVE`, 640: visible pixels per line.
- `H_TOTAL`, 800: pixel clocks per line.
- `V_ACTIVE`, 480: visible lines.
- `V_TOTAL`, 525: lines per frame.
- `FB_W`, 160: cells per row (H_ACTIVE/4).
- `FB_CELLS`, 19200: total cells (FB_W × V_ACTIVE/4).

Ports (one clock `clk`; reset `rst` is synchronous and active-high):

- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `hcount` in 10: current pixel column, 0..H_TOTAL-1, from the timing generator.
- `vcount` in 10: current line, 0..V_TOTAL-1.
- `host_valid` in 1: host request present.
- `host_ready` out 1: request accepted this cycle.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in 15: cell index.
- `host_wdata` in 3: RGB to write.
- `host_rvalid` out 1: read data valid.
- `host_rdata` out 3: read data.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: RAM write strobe.
- `mem_addr` out 15: RAM address.
- `mem_wdata` out 3: RAM write data.
- `mem_rdata` in 3: RAM read data, valid the cycle after `mem_en` with `mem_we`=0.
- `pix_rgb` out 3: {r,g,b} for the pixel; 0 when blanked.

## Operation

Display slots:

- A display slot is a cycle with `hcount[1:0]`==2'b10 in which the lookahead cell is visible.
  - For hcount 2..634 with vcount<V_ACTIVE: nx=(hcount+2)>>2 and ny=vcount>>2.
  - For hcount==H_TOTAL-2 (798): nx=0, nl=(vcount==V_TOTAL-1)?0:vcount+1, and the slot exists only if nl<V_ACTIVE; ny=nl>>2.
  - No other cycle is a display slot. Horizontal blanking after hcount 634 and the whole vertical blanking interval go entirely to the host.
- In a display slot: `mem_en`=1, `mem_we`=0, `mem_addr`=ny*FB_W+nx. The multiply is by a constant 160 (shift-add), 15-bit result.

Cell register:

- `cell_reg` ← `mem_rdata` at the end of the cycle following a display slot.

Output:

- `pix_rgb` is registered. At the end of cycle t it is loaded with `cell_reg` if (hcount<H_ACTIVE && vcount<V_ACTIVE), else 0.
- Each row of cells is fetched on 4 consecutive lines (the same ny).

Host port:

- `host_ready` = !rst && !display_slot. It is independent of `host_valid`; acceptance means `host_valid && host_ready`.
- On an accepted request with `host_addr`<FB_CELLS: `mem_en`=1, `mem_we`=`host_we`, and `mem_addr`/`mem_wdata` are taken from the host, all combinationally in the same cycle.
- On an accepted request with `host_addr`≥FB_CELLS:
  - `mem_en`=0.
  - A write is dropped.
  - A read still returns `host_rvalid` with `host_rdata`=0.
- Accepted read → `host_rvalid`=1 in the next cycle, with `host_rdata`=`mem_rdata` (or 0 if out of range). `host_rvalid` is a single-cycle pulse per read. Back-to-back reads are allowed.
- The host must hold its request stable while `host_valid`=1 and `host_ready`=0.

Idle:

- No slot and no accepted request: `mem_en`=0, `mem_we`=0; `mem_addr`/`mem_wdata` are don't-care, driven 0.

## Timing

- Reset values: `pix_rgb`=0, `cell_reg`=0, `host_rvalid`=0, `host_rdata`=0.
- While `rst`=1: `host_ready`=0 and `mem_en`=`mem_we`=0.
- Reset mid-operation: a read in flight when `rst` rises produces no `host_rvalid`. The first display fetch after reset waits for the next qualifying slot.
- Fetch-to-pixel latency:
  - Slot at hcount=4k+2 → `cell_reg` valid from hcount=4k+4.
  - `pix_rgb` for pixel (h,v) appears in the cycle after `hcount`=h, `vcount`=v are presented (1-cycle latency, matching the sync path).
- Wrap cases:
  - hcount 798 on line 524 fetches cell 0 of frame line 0.
  - hcount 798 on line 479 has no slot, because nl=480.
- Host bandwidth: 3 of every 4 cycles during visible lines. Full bandwidth during blanking and vblank. Host latency is never more than 2 cycles waiting for a slot to pass.

## Test plan

- Reset: hold `rst`=1 for 3 cycles with `host_valid`=1 → `host_ready`=0, `mem_en`=0, `pix_rgb`=0, `host_rvalid`=0 throughout.
- Vblank writes: vcount=500, host writes addr 0 = 3'b100 and addr 1 = 3'b010 on consecutive cycles → `host_ready`=1 both cycles, `mem_we`=1 with matching `mem_addr`/`mem_wdata` in the same cycles.
- Scan-out:
  - At vcount=524, hcount=798 → `mem_en`=1, `mem_addr`=0.
  - On line 0, `pix_rgb`=3'b100 one cycle after hcount 0..3, then 3'b010 after hcount 4..7.
  - `pix_rgb`=0 after hcount≥640.
- Contention: `host_valid` held high across visible line 10 → `host_ready`=0 exactly at hcount ∈ {2,6,…,634,798}, 1 elsewhere; no request is lost or duplicated.
- Host read: read addr 1 → `host_rvalid`=1 next cycle, `host_rdata`=3'b010. Read addr 19200 → accepted, `mem_en`=0, `host_rvalid`=1, `host_rdata`=0.
- Row repeat and edge:
  - vcount=3 → hcount 2 fetches `mem_addr`=1.
  - vcount=4 → hcount 2 fetches `mem_addr`=161.
  - vcount=479 → no `mem_en` from display at hcount 798.
